// File: rtl/ps2_note_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ps2_note_decoder
// Brief    : PS/2 set-2 frame receiver and note-key decoder driving the seven
//            held-note flags. Optional PS/2 clock filter: PS2_GLITCH_FILTER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_note_decoder #(
    parameter int TIMEOUT_CYCLES = 25000
) (
    input  logic       iCLK,
    input  logic       iRST_n,
    input  logic       iPS2_CLK,
    input  logic       iPS2_DAT,
    output logic [6:0] oKEYS,
    output logic [7:0] oBYTE,
    output logic       oBYTE_VALID,
    output logic       oFRAME_ERR
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_BREAK     = 2'd1,
        ST_EXT       = 2'd2,
        ST_EXT_BREAK = 2'd3
    } state_t;

    logic             clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic             clk_lvl_w, clk_prev_q, fall_w, good_w;
    logic [3:0]       bitcnt_q;
    logic [9:0]       shift_q;
    logic [TMR_W-1:0] tmr_q;
    logic [7:0]       byte_q;
    logic             valid_q, err_q;
    state_t           state_q, state_d;
    logic [6:0]       keys_q, keys_d, mask_w;

    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= iPS2_CLK;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= iPS2_DAT;
            dat_s2_q <= dat_s1_q;
        end
    end

`ifdef PS2_GLITCH_FILTER_EN
    logic       clk_filt_q;
    logic [2:0] flt_cnt_q;

    // Filtered level flips on the 8th consecutive sample that disagrees with it
    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            clk_filt_q <= 1'b1;
            flt_cnt_q  <= 3'd0;
        end else if (clk_s2_q == clk_filt_q) begin
            flt_cnt_q  <= 3'd0;
        end else if (flt_cnt_q == 3'd7) begin
            clk_filt_q <= clk_s2_q;
            flt_cnt_q  <= 3'd0;
        end else begin
            flt_cnt_q  <= flt_cnt_q + 3'd1;
        end
    end

    assign clk_lvl_w = clk_filt_q;
`else
    assign clk_lvl_w = clk_s2_q;
`endif

    always_ff @(posedge iCLK) begin
        if (!iRST_n) clk_prev_q <= 1'b1;
        else         clk_prev_q <= clk_lvl_w;
    end

    assign fall_w = clk_prev_q & ~clk_lvl_w;
    // shift_q holds start..parity with start at bit 0; stop bit is the live sample
    assign good_w = ~shift_q[0] & (^shift_q[9:1]) & dat_s2_q;

    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            bitcnt_q <= 4'd0;
            shift_q  <= 10'd0;
            tmr_q    <= '0;
            byte_q   <= 8'd0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (fall_w) begin
                tmr_q <= '0;
                if (bitcnt_q == 4'd10) begin
                    bitcnt_q <= 4'd0;
                    if (good_w) begin
                        byte_q  <= shift_q[8:1];
                        valid_q <= 1'b1;
                    end else begin
                        err_q   <= 1'b1;
                    end
                end else begin
                    shift_q  <= {dat_s2_q, shift_q[9:1]};
                    bitcnt_q <= bitcnt_q + 4'd1;
                end
            end else if (bitcnt_q != 4'd0) begin
                if (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    bitcnt_q <= 4'd0;
                    tmr_q    <= '0;
                end else begin
                    tmr_q    <= tmr_q + TMR_W'(1);
                end
            end
        end
    end

    function automatic logic [6:0] note_mask(input logic [7:0] code);
        case (code)
            8'h1C:   note_mask = 7'b0000001;
            8'h1B:   note_mask = 7'b0000010;
            8'h23:   note_mask = 7'b0000100;
            8'h2B:   note_mask = 7'b0001000;
            8'h34:   note_mask = 7'b0010000;
            8'h33:   note_mask = 7'b0100000;
            8'h3B:   note_mask = 7'b1000000;
            default: note_mask = 7'b0000000;
        endcase
    endfunction

    assign mask_w = note_mask(byte_q);

    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            state_q <= ST_IDLE;
            keys_q  <= 7'd0;
        end else begin
            state_q <= state_d;
            keys_q  <= keys_d;
        end
    end

    always_comb begin
        state_d = state_q;
        keys_d  = keys_q;
        if (valid_q) begin
            case (state_q)
                ST_IDLE: begin
                    if (byte_q == 8'hF0)      state_d = ST_BREAK;
                    else if (byte_q == 8'hE0) state_d = ST_EXT;
                    else                      keys_d  = keys_q | mask_w;
                end
                ST_BREAK: begin
                    keys_d  = keys_q & ~mask_w;
                    state_d = ST_IDLE;
                end
                ST_EXT: begin
                    state_d = (byte_q == 8'hF0) ? ST_EXT_BREAK : ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign oKEYS       = keys_q;
    assign oBYTE       = byte_q;
    assign oBYTE_VALID = valid_q;
    assign oFRAME_ERR  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_note_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_note_decoder
// Brief    : Directed bench for ps2_note_decoder with a byte/error scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_note_decoder;

    localparam int TIMEOUT_CYCLES = 25000;

    typedef struct packed {
        logic       err;
        logic [7:0] b;
    } ev_t;

    logic       iCLK = 1'b0;
    logic       iRST_n = 1'b0;
    logic       iPS2_CLK = 1'b1;
    logic       iPS2_DAT = 1'b1;
    logic [6:0] oKEYS;
    logic [7:0] oBYTE;
    logic       oBYTE_VALID;
    logic       oFRAME_ERR;

    ev_t        exp_q[$];
    logic [7:0] last_good = 8'h00;
    int         n_assert = 0;
    int         n_fail = 0;

    ps2_note_decoder #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .iCLK        (iCLK),
        .iRST_n      (iRST_n),
        .iPS2_CLK    (iPS2_CLK),
        .iPS2_DAT    (iPS2_DAT),
        .oKEYS       (oKEYS),
        .oBYTE       (oBYTE),
        .oBYTE_VALID (oBYTE_VALID),
        .oFRAME_ERR  (oFRAME_ERR)
    );

    always #5 iCLK = ~iCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_event();
        ev_t e;
        n_assert++;
        assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL unexpected_pulse observed valid=%0b err=%0b expected no pulse",
                   oBYTE_VALID, oFRAME_ERR);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("pulse_valid", 32'(oBYTE_VALID), 32'(!e.err));
            chk("pulse_err", 32'(oFRAME_ERR), 32'(e.err));
            chk("pulse_byte", 32'(oBYTE), 32'(e.err ? last_good : e.b));
            if (!e.err) last_good = e.b;
        end
    endtask

    // Every waited cycle also watches the DUT for result pulses
    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(negedge iCLK);
            if (oBYTE_VALID || oFRAME_ERR) check_event();
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input logic bad_par, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        if (nbits == 11) exp_q.push_back('{err: bad_par, b: b});
        for (int i = 0; i < nbits; i++) begin
            iPS2_DAT = f[i];
            wait_cycles(10);
            iPS2_CLK = 1'b0;
            wait_cycles(20);
            iPS2_CLK = 1'b1;
            wait_cycles(10);
        end
        iPS2_DAT = 1'b1;
        if (nbits == 11) begin
            wait_cycles(20);
            chk("pending", 32'(exp_q.size()), 32'd0);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 1'b0, 11);
    endtask

    initial begin
        repeat (3) @(negedge iCLK);
        chk("rst_keys", 32'(oKEYS), 32'd0);
        chk("rst_byte", 32'(oBYTE), 32'd0);
        chk("rst_valid", 32'(oBYTE_VALID), 32'd0);
        chk("rst_err", 32'(oFRAME_ERR), 32'd0);
        iRST_n = 1'b1;
        wait_cycles(20);

        send_byte(8'h1C);
        chk("keys_c", 32'(oKEYS), 32'h01);

        send_byte(8'h34);
        chk("keys_cg", 32'(oKEYS), 32'h11);
        send_byte(8'hF0);
        chk("keys_after_f0", 32'(oKEYS), 32'h11);
        send_byte(8'h1C);
        chk("keys_release_c", 32'(oKEYS), 32'h10);
        send_byte(8'hF0);
        send_byte(8'h34);
        chk("keys_release_g", 32'(oKEYS), 32'h00);

        send_byte(8'hE0);
        send_byte(8'h1C);
        chk("keys_ext_make", 32'(oKEYS), 32'h00);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h1C);
        chk("keys_ext_break", 32'(oKEYS), 32'h00);
        send_byte(8'h3B);
        chk("keys_b", 32'(oKEYS), 32'h40);

        send_bits(8'h23, 1'b1, 11);
        chk("keys_after_err", 32'(oKEYS), 32'h40);
        chk("byte_after_err", 32'(oBYTE), 32'h3B);

        send_bits(8'h2B, 1'b0, 5);
        wait_cycles(TIMEOUT_CYCLES + 1);
        send_byte(8'h2B);
        chk("byte_after_timeout", 32'(oBYTE), 32'h2B);
        chk("keys_after_timeout", 32'(oKEYS), 32'h48);

        // Abort a frame with reset while the PS/2 clock is high in bit 4
        send_bits(8'h55, 1'b0, 4);
        iPS2_DAT = 1'b1;
        wait_cycles(5);
        iRST_n = 1'b0;
        @(negedge iCLK);
        iRST_n = 1'b1;
        chk("midrst_keys", 32'(oKEYS), 32'd0);
        chk("midrst_byte", 32'(oBYTE), 32'd0);
        chk("midrst_valid", 32'(oBYTE_VALID), 32'd0);
        chk("midrst_err", 32'(oFRAME_ERR), 32'd0);
        last_good = 8'h00;
        wait_cycles(50);
        send_byte(8'h33);
        chk("keys_a", 32'(oKEYS), 32'h20);
        chk("byte_a", 32'(oBYTE), 32'h33);

`ifdef PS2_GLITCH_FILTER_EN
        iPS2_CLK = 1'b0;
        wait_cycles(3);
        iPS2_CLK = 1'b1;
        wait_cycles(40);
        send_byte(8'h1C);
        chk("glitch_byte", 32'(oBYTE), 32'h1C);
        chk("glitch_keys", 32'(oKEYS), 32'h21);
`endif

        wait_cycles(50);
        chk("final_pending", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_note_decoder.md
# ps2_note_decoder

Receives PS/2 keyboard frames (scan-code set 2) and produces the seven held-note flags, C D E F G A B, that the VGA key-highlight logic and the tone generators consume. It sits between the board PS/2 pins and the note-flag inputs of the display and audio paths. It runs entirely in the system clock domain; the PS/2 lines are treated as asynchronous inputs.

## Interface
- TIMEOUT_CYCLES, 25000: idle system-clock cycles after which a partial frame is discarded.
- iCLK  in  1  system clock; all logic on rising edge.
- iRST_n  in  1  synchronous, active-low reset.
- iPS2_CLK  in  1  PS/2 clock pin, asynchronous, idle high.
- iPS2_DAT  in  1  PS/2 data pin, asynchronous, idle high.
- oKEYS  out  7  held flags: bit0=C, bit1=D, bit2=E, bit3=F, bit4=G, bit5=A, bit6=B.
- oBYTE  out  8  last correctly received byte.
- oBYTE_VALID  out  1  one-cycle pulse when oBYTE is updated.
- oFRAME_ERR  out  1  one-cycle pulse on a bad start, parity or stop bit.

## Operation
- Input conditioning: both pins pass through 2-flop synchronizers that reset to 1. A falling edge is synced clock high in the previous cycle and low in the current cycle.
- Frame receiver:
  - Bit counter 0..10 samples synced data on each falling edge: start, d0..d7 LSB first, odd parity, stop.
  - At bit 10, the frame is good when start=0, ^{d,parity}=1 and stop=1.
  - Good frame: load oBYTE and pulse oBYTE_VALID.
  - Bad frame: pulse oFRAME_ERR; oBYTE is unchanged.
  - In both cases the counter returns to 0.
- Timeout:
  - The counter runs only while the bit count is nonzero.
  - After TIMEOUT_CYCLES cycles with no falling edge, the bit count resets to 0. No error pulse is raised.
  - If a falling edge arrives in the same cycle as the timeout, the edge wins: the bit is captured and the timer clears.
- Note map (make codes): 1C→C, 1B→D, 23→E, 2B→F, 34→G, 33→A, 3B→B.
- Decoder FSM, advanced only on oBYTE_VALID:
  - IDLE: F0→BREAK; E0→EXT; mapped code→set its flag, stay IDLE; other codes ignored.
  - BREAK: mapped code→clear its flag; any byte→IDLE.
  - EXT: F0→EXT_BREAK; any other byte→IDLE, no flag change.
  - EXT_BREAK: any byte→IDLE, no flag change.
- Typematic repeats of a make code re-set an already-set flag; this is harmless.
- Several flags may be set at once; there is no limit.
- A frame error does not change the FSM state or the flags.

## Timing
- Reset (iRST_n low at a rising edge): oKEYS=0, oBYTE=0, oBYTE_VALID=0, oFRAME_ERR=0, FSM=IDLE, bit count=0, timer=0, synchronizers=1.
- Reset asserted mid-frame aborts the frame. No pulse is produced.
- Pin edge to detected falling edge: 3 cycles without the filter.
- oBYTE_VALID / oFRAME_ERR assert in the cycle after the detected stop-bit edge, for exactly one cycle.
- oKEYS change one cycle after the oBYTE_VALID pulse that triggers them.
- The design assumes iCLK ≥ 20× the PS/2 clock rate. The maximum PS/2 rate is 16.7 kHz.

## Configuration
- PS2_GLITCH_FILTER_EN defined:
  - The synced PS/2 clock feeds an 8-cycle filter.
  - The filtered level changes only after 8 consecutive identical samples.
  - Edge detection uses the filtered level; pin-to-edge latency becomes 11 cycles.
  - Pulses shorter than 8 cycles are ignored.
- Not defined: edges are detected directly from the 2-flop synchronizer output, with 3-cycle latency and no filtering.

## Test plan
- Reset, then frame 0x1C (parity 0, odd total) → oBYTE=0x1C, one oBYTE_VALID pulse, oKEYS=7'b0000001 one cycle later.
- With oKEYS=7'b0000001, send 0x34, then F0 1C → oKEYS=7'b0010000 after the 0x1C byte; no change after F0.
- Send E0 1C, then E0 F0 1C → oKEYS stays 0; FSM ends in IDLE; a following 0x3B sets bit6.
- Frame 0x23 with a corrupted parity bit → oFRAME_ERR pulses once, no oBYTE_VALID, oBYTE and oKEYS unchanged.
- Send 5 bits, stall TIMEOUT_CYCLES+1 cycles, then a full 0x2B frame → no error pulse; oBYTE=0x2B; bit3 set.
- Assert iRST_n=0 for one cycle during bit 4 of a frame → all outputs 0. The next full 0x33 frame sets bit5. With PS2_GLITCH_FILTER_EN, a 3-cycle low glitch on iPS2_CLK captures no bit.
